// File: rtl/mem_arb_pkg.sv
// Shared definitions for the MCB write-port arbiter.
// It holds the FSM state encodings, the MCB user-port field widths and the MCB write instruction.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_DRAIN  = 2'd3
  } arb_state_t;

  localparam int INSTR_W = 3;
  localparam int BL_W    = 6;
  localparam int ADDR_W  = 30;
  localparam int MASK_W  = 4;
  localparam int DATA_W  = 32;
  localparam int HOLD_W  = 16;

  localparam logic [INSTR_W-1:0] MCB_INSTR_WRITE = 3'b000;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  function automatic logic pick_port1(input logic req_0, input logic req_1, input logic last);
    return req_1 && (!req_0 || !last);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single MCB write port between the SD boot loader (port 0) and the CPU/GPU path (port 1).
// Ownership is locked while req is high, and the MCB FIFOs drain before the port is handed over.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int HOLD_MAX = 65535
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                req_0,
  input  logic                req_1,
  output logic                gnt_0,
  output logic                gnt_1,

  input  logic                cmd_en_0,
  input  logic [INSTR_W-1:0]  cmd_instr_0,
  input  logic [BL_W-1:0]     cmd_bl_0,
  input  logic [ADDR_W-1:0]   cmd_byte_addr_0,
  input  logic                wr_en_0,
  input  logic [MASK_W-1:0]   wr_mask_0,
  input  logic [DATA_W-1:0]   wr_data_0,
  output logic                cmd_full_0,
  output logic                wr_full_0,

  input  logic                cmd_en_1,
  input  logic [INSTR_W-1:0]  cmd_instr_1,
  input  logic [BL_W-1:0]     cmd_bl_1,
  input  logic [ADDR_W-1:0]   cmd_byte_addr_1,
  input  logic                wr_en_1,
  input  logic [MASK_W-1:0]   wr_mask_1,
  input  logic [DATA_W-1:0]   wr_data_1,
  output logic                cmd_full_1,
  output logic                wr_full_1,

  output logic                mem_cmd_en,
  output logic [INSTR_W-1:0]  mem_cmd_instr,
  output logic [BL_W-1:0]     mem_cmd_bl,
  output logic [ADDR_W-1:0]   mem_cmd_byte_addr,
  output logic                mem_wr_en,
  output logic [MASK_W-1:0]   mem_wr_mask,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic                mem_cmd_full,
  input  logic                mem_cmd_empty,
  input  logic                mem_wr_full,
  input  logic                mem_wr_empty,

  output logic [1:0]          owner,
  output logic                timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

  arb_state_t        state;
  logic              last;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              owner_req;

  assign hold_next = hold_cnt + 16'd1;
  assign owner_req = (state == ST_GRANT0) ? req_0 : req_1;

  // The hold counter only advances while a grant is live and sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      gnt_0    <= 1'b0;
      gnt_1    <= 1'b0;
      last     <= 1'b1;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_0 || req_1) begin
            hold_cnt <= '0;
            if (pick_port1(req_0, req_1, last)) begin
              state <= ST_GRANT1;
              gnt_1 <= 1'b1;
              last  <= 1'b1;
            end else begin
              state <= ST_GRANT0;
              gnt_0 <= 1'b1;
              last  <= 1'b0;
            end
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (!owner_req) begin
            state <= ST_DRAIN;
            gnt_0 <= 1'b0;
            gnt_1 <= 1'b0;
          end
          if (hold_cnt != '1) begin
            hold_cnt <= hold_next;
            if (HOLD_MAX != 0 && hold_next == HOLD_LIMIT)
              timeout <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (mem_cmd_empty && mem_wr_empty)
            state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          gnt_0 <= 1'b0;
          gnt_1 <= 1'b0;
        end
      endcase
    end
  end

  // Strobes from whichever port is not granted never reach the MCB.
  always_comb begin
    mem_cmd_en        = 1'b0;
    mem_cmd_instr     = '0;
    mem_cmd_bl        = '0;
    mem_cmd_byte_addr = '0;
    mem_wr_en         = 1'b0;
    mem_wr_mask       = '0;
    mem_wr_data       = '0;
    if (gnt_0) begin
      mem_cmd_en        = cmd_en_0;
      mem_cmd_instr     = cmd_instr_0;
      mem_cmd_bl        = cmd_bl_0;
      mem_cmd_byte_addr = cmd_byte_addr_0;
      mem_wr_en         = wr_en_0;
      mem_wr_mask       = wr_mask_0;
      mem_wr_data       = wr_data_0;
    end else if (gnt_1) begin
      mem_cmd_en        = cmd_en_1;
      mem_cmd_instr     = cmd_instr_1;
      mem_cmd_bl        = cmd_bl_1;
      mem_cmd_byte_addr = cmd_byte_addr_1;
      mem_wr_en         = wr_en_1;
      mem_wr_mask       = wr_mask_1;
      mem_wr_data       = wr_data_1;
    end
  end

  assign cmd_full_0 = mem_cmd_full | ~gnt_0;
  assign wr_full_0  = mem_wr_full  | ~gnt_0;
  assign cmd_full_1 = mem_cmd_full | ~gnt_1;
  assign wr_full_1  = mem_wr_full  | ~gnt_1;
  assign owner      = {gnt_1, gnt_0};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected MCB writes/commands go into queues and a
// negedge monitor pops and compares them whenever the MCB strobes are asserted.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_0, req_1, gnt_0, gnt_1;
  logic        cmd_en_0, cmd_en_1, wr_en_0, wr_en_1;
  logic [2:0]  cmd_instr_0, cmd_instr_1;
  logic [5:0]  cmd_bl_0, cmd_bl_1;
  logic [29:0] cmd_byte_addr_0, cmd_byte_addr_1;
  logic [3:0]  wr_mask_0, wr_mask_1;
  logic [31:0] wr_data_0, wr_data_1;
  logic        cmd_full_0, wr_full_0, cmd_full_1, wr_full_1;
  logic        mem_cmd_en, mem_wr_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_wr_data;
  logic        mem_cmd_full, mem_cmd_empty, mem_wr_full, mem_wr_empty;
  logic [1:0]  owner;
  logic        timeout;

  logic [35:0] exp_wr[$];
  logic [38:0] exp_cmd[$];
  int n_vec = 0;
  int n_err = 0;
  int wr_seen = 0;
  int cmd_seen = 0;
  int beef_seen = 0;

  mem_port_arbiter #(.HOLD_MAX(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .req_1(req_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .cmd_en_0(cmd_en_0), .cmd_instr_0(cmd_instr_0), .cmd_bl_0(cmd_bl_0),
    .cmd_byte_addr_0(cmd_byte_addr_0), .wr_en_0(wr_en_0), .wr_mask_0(wr_mask_0),
    .wr_data_0(wr_data_0), .cmd_full_0(cmd_full_0), .wr_full_0(wr_full_0),
    .cmd_en_1(cmd_en_1), .cmd_instr_1(cmd_instr_1), .cmd_bl_1(cmd_bl_1),
    .cmd_byte_addr_1(cmd_byte_addr_1), .wr_en_1(wr_en_1), .wr_mask_1(wr_mask_1),
    .wr_data_1(wr_data_1), .cmd_full_1(cmd_full_1), .wr_full_1(wr_full_1),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data),
    .mem_cmd_full(mem_cmd_full), .mem_cmd_empty(mem_cmd_empty),
    .mem_wr_full(mem_wr_full), .mem_wr_empty(mem_wr_empty),
    .owner(owner), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [3:0] mask, input logic [31:0] data,
                               input bit expect_pass);
    if (port == 0) begin
      wr_en_0 = 1'b1; wr_mask_0 = mask; wr_data_0 = data;
    end else begin
      wr_en_1 = 1'b1; wr_mask_1 = mask; wr_data_1 = data;
    end
    if (expect_pass) exp_wr.push_back({mask, data});
  endtask

  task automatic applyCommand(input int port, input logic [2:0] instr, input logic [5:0] bl,
                              input logic [29:0] addr, input bit expect_pass);
    if (port == 0) begin
      cmd_en_0 = 1'b1; cmd_instr_0 = instr; cmd_bl_0 = bl; cmd_byte_addr_0 = addr;
    end else begin
      cmd_en_1 = 1'b1; cmd_instr_1 = instr; cmd_bl_1 = bl; cmd_byte_addr_1 = addr;
    end
    if (expect_pass) exp_cmd.push_back({instr, bl, addr});
  endtask

  task automatic clearStrobes();
    wr_en_0 = 1'b0; wr_mask_0 = '0; wr_data_0 = '0;
    wr_en_1 = 1'b0; wr_mask_1 = '0; wr_data_1 = '0;
    cmd_en_0 = 1'b0; cmd_instr_0 = '0; cmd_bl_0 = '0; cmd_byte_addr_0 = '0;
    cmd_en_1 = 1'b0; cmd_instr_1 = '0; cmd_bl_1 = '0; cmd_byte_addr_1 = '0;
  endtask

  // Every MCB strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_wr_en) begin
        logic [35:0] ew;
        wr_seen++;
        if (mem_wr_data == 32'hDEADBEEF) beef_seen++;
        n_vec++;
        if (exp_wr.size() == 0) begin
          n_err++;
          $display("[TB] FAIL wr_unexpected: got mask %0h data %0h, expected no write",
                   mem_wr_mask, mem_wr_data);
        end else begin
          ew = exp_wr.pop_front();
          if ({mem_wr_mask, mem_wr_data} !== ew) begin
            n_err++;
            $display("[TB] FAIL wr_word: got %0h, expected %0h", {mem_wr_mask, mem_wr_data}, ew);
          end
        end
      end
      if (mem_cmd_en) begin
        logic [38:0] ec;
        cmd_seen++;
        n_vec++;
        if (exp_cmd.size() == 0) begin
          n_err++;
          $display("[TB] FAIL cmd_unexpected: got addr %0h, expected no command", mem_cmd_byte_addr);
        end else begin
          ec = exp_cmd.pop_front();
          if ({mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr} !== ec) begin
            n_err++;
            $display("[TB] FAIL cmd_word: got %0h, expected %0h",
                     {mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}, ec);
          end
        end
      end
    end
  end

  initial begin
    int wr0, cmd0, beef0;
    bit revoked;
    reset_n = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0;
    clearStrobes();
    mem_cmd_full = 1'b0; mem_wr_full = 1'b0;
    mem_cmd_empty = 1'b1; mem_wr_empty = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_gnt_0", gnt_0, 0);
    checkOutput("rst_gnt_1", gnt_1, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_mem_wr_en", mem_wr_en, 0);
    checkOutput("rst_mem_cmd_en", mem_cmd_en, 0);
    checkOutput("rst_cmd_full_0", cmd_full_0, 1);
    reset_n = 1'b1;
    tick();

    // Idle strobe is dropped
    applyStimulus(0, 4'hF, 32'h11111111, 0);
    checkOutput("idle_wr_full_0", wr_full_0, 1);
    tick();
    clearStrobes();

    // Tie after reset goes to port 0, then port 1, then port 0 again
    req_0 = 1; req_1 = 1;
    tick();
    checkOutput("tie1_gnt_0", gnt_0, 1);
    checkOutput("tie1_gnt_1", gnt_1, 0);
    checkOutput("tie1_owner", owner, 2'b01);
    checkOutput("tie1_cmd_full_0", cmd_full_0, 0);
    checkOutput("tie1_cmd_full_1", cmd_full_1, 1);
    req_0 = 0;
    tick();
    checkOutput("drain_owner", owner, 0);
    tick();
    checkOutput("idle_gnt_1", gnt_1, 0);
    tick();
    checkOutput("tie2_gnt_1", gnt_1, 1);
    checkOutput("tie2_owner", owner, 2'b10);
    req_0 = 1; req_1 = 0;
    tick();
    checkOutput("rel1_gnt_1", gnt_1, 0);
    req_1 = 1;
    tick();
    tick();
    checkOutput("tie3_gnt_0", gnt_0, 1);
    checkOutput("tie3_gnt_1", gnt_1, 0);
    req_0 = 0; req_1 = 0;
    tick();
    tick();

    // Single requester: 16 words and one command
    req_0 = 1;
    checkOutput("single_gnt_0_t", gnt_0, 0);
    tick();
    checkOutput("single_gnt_0_t1", gnt_0, 1);
    wr0 = wr_seen; cmd0 = cmd_seen;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 4'h0, 32'hA0000000 + i, 1);
      if (i == 7) applyCommand(0, MCB_INSTR_WRITE, 6'd15, 30'h200, 1);
      tick();
      clearStrobes();
    end
    req_0 = 0;
    applyStimulus(0, 4'h3, 32'hA000000F, 1);
    tick();
    clearStrobes();
    checkOutput("single_rel_gnt_0", gnt_0, 0);
    tick();
    checkOutput("single_wr_count", 40'(wr_seen - wr0), 16);
    checkOutput("single_cmd_count", 40'(cmd_seen - cmd0), 1);

    // Drain hold with write FIFO not empty
    req_0 = 1;
    tick();
    req_1 = 1;
    tick();
    req_0 = 0; mem_wr_empty = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput("drain_hold_gnt_1", gnt_1, 0);
      applyStimulus(0, 4'hF, 32'h22222222, 0);
      tick();
      clearStrobes();
    end
    mem_wr_empty = 1;
    checkOutput("drain_e0_gnt_1", gnt_1, 0);
    tick();
    checkOutput("drain_e1_gnt_1", gnt_1, 0);
    tick();
    checkOutput("drain_e2_gnt_1", gnt_1, 1);

    // Isolation: port 1 writes DEADBEEF while port 0 owns
    req_1 = 0;
    tick();
    tick();
    req_0 = 1;
    tick();
    beef0 = beef_seen;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1, 4'h0, 32'hDEADBEEF, 0);
        applyCommand(1, MCB_INSTR_WRITE, 6'd63, 30'h3FFFFFFF, 0);
      end
      applyStimulus(0, 4'h0, 32'hB0000000 + i, 1);
      checkOutput("iso_wr_full_1", wr_full_1, 1);
      checkOutput("iso_wr_full_0", wr_full_0, 0);
      tick();
      clearStrobes();
    end
    req_0 = 0;
    tick();
    tick();
    checkOutput("iso_beef_count", 40'(beef_seen - beef0), 0);

    // Timeout after 100 grant cycles, grant kept
    checkOutput("pre_timeout", timeout, 0);
    req_1 = 1;
    tick();
    revoked = 0;
    for (int k = 1; k <= 150; k++) begin
      checkOutput("hold_timeout", timeout, (k >= 101) ? 1 : 0);
      if (gnt_1 !== 1'b1) revoked = 1;
      if (k == 5) applyCommand(1, MCB_INSTR_WRITE, 6'd3, 30'h1000, 1);
      tick();
      clearStrobes();
    end
    checkOutput("hold_never_revoked", revoked, 0);
    req_1 = 0;
    tick();
    checkOutput("hold_rel_gnt_1", gnt_1, 0);
    checkOutput("hold_sticky_timeout", timeout, 1);
    tick();

    // Asynchronous reset mid-burst in GRANT1
    req_1 = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'h0, 32'hC0000000 + i, 1);
      tick();
      clearStrobes();
    end
    applyStimulus(1, 4'hF, 32'hC0DE0000, 0);
    applyCommand(1, MCB_INSTR_WRITE, 6'd7, 30'h2000, 0);
    #1 reset_n = 0;
    #1;
    checkOutput("arst_gnt_1", gnt_1, 0);
    checkOutput("arst_owner", owner, 0);
    checkOutput("arst_timeout", timeout, 0);
    checkOutput("arst_mem_wr_en", mem_wr_en, 0);
    checkOutput("arst_mem_wr_data", mem_wr_data, 0);
    checkOutput("arst_mem_cmd_en", mem_cmd_en, 0);
    checkOutput("arst_mem_cmd_addr", mem_cmd_byte_addr, 0);
    checkOutput("arst_wr_full_1", wr_full_1, 1);
    clearStrobes();
    req_1 = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
    req_0 = 1; req_1 = 1;
    tick();
    checkOutput("post_rst_tie_gnt_0", gnt_0, 1);
    checkOutput("post_rst_tie_gnt_1", gnt_1, 0);
    req_0 = 0; req_1 = 0;
    tick();
    tick();

    checkOutput("wr_queue_left", exp_wr.size(), 0);
    checkOutput("cmd_queue_left", exp_cmd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single MCB write port (command FIFO plus write-data FIFO) between two requesters: port 0, the SD card boot loader, and port 1, the CPU/GPU write path. It grants the port to one requester at a time with a request/grant lock and drains the MCB FIFOs before handing over, so bursts from different owners never interleave. It sits between the requesters and the MCB user port and is the only block that drives the MCB `mem_cmd_*` and `mem_wr_*` inputs.

## Interface
- `HOLD_MAX`, default 65535: cycles a grant may be held before `timeout` sets. 0 disables the check.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_0` / `req_1`  in  1  requester holds high for the whole ownership period.
- `gnt_0` / `gnt_1`  out  1  registered grant, one-hot or zero.
- `cmd_en_N`, `cmd_instr_N`, `cmd_bl_N`, `cmd_byte_addr_N`  in  1/3/6/30  per-port command, N∈{0,1}.
- `wr_en_N`, `wr_mask_N`, `wr_data_N`  in  1/4/32  per-port write data.
- `cmd_full_N`, `wr_full_N`  out  1  per-port back-pressure.
- `mem_cmd_en`, `mem_cmd_instr`, `mem_cmd_bl`, `mem_cmd_byte_addr`  out  1/3/6/30  to MCB.
- `mem_wr_en`, `mem_wr_mask`, `mem_wr_data`  out  1/4/32  to MCB.
- `mem_cmd_full`, `mem_cmd_empty`, `mem_wr_full`, `mem_wr_empty`  in  1  MCB status.
- `owner`  out  2  {gnt_1, gnt_0}, for debug LEDs.
- `timeout`  out  1  sticky; set when a grant is held too long.

## Operation
- FSM states:
  - IDLE.
  - GRANT0.
  - GRANT1.
  - DRAIN.
- IDLE: if exactly one `req` is high, go to that port's GRANT state. If both are high, grant the port other than `last`. `last` resets to 1, so port 0 wins the first tie. On entering GRANTn, `last <= n`.
- GRANTn: `gnt_n = 1`. When `req_n` falls, go to DRAIN. The other port's `req` is ignored.
- DRAIN: both grants low. Wait until `mem_cmd_empty && mem_wr_empty`, then go to IDLE.
- Output mux:
  - All `mem_*` outputs are driven from the granted port.
  - In IDLE and DRAIN, `mem_cmd_en` and `mem_wr_en` are forced to 0, and data/address outputs are 0.
  - Strobes from an ungranted port are dropped silently.
- Back-pressure:
  - `cmd_full_N = mem_cmd_full | ~gnt_N`.
  - `wr_full_N = mem_wr_full | ~gnt_N`.
- Hold counter:
  - 16-bit, cleared on grant entry, increments each GRANT cycle, saturates.
  - When it equals `HOLD_MAX` with `HOLD_MAX != 0`, set `timeout`. It stays set until reset.
  - The grant is NOT revoked on timeout.
- Reset values:
  - state = IDLE.
  - `gnt_0`, `gnt_1`, `owner`, `timeout` = 0.
  - `last` = 1.
  - Hold counter = 0.
  - All `mem_*` outputs = 0.

## Timing
- Grant latency: `req` high in cycle t (state IDLE) gives `gnt` high in cycle t+1. Strobes are passed from t+1.
- Mux and full gating are combinational from registered state: zero latency from port to MCB.
- Release: `req_n` low in cycle t means `gnt_n` is low from t+1. A strobe asserted in cycle t while `gnt_n` is still high is passed.
- Minimum DRAIN time is 1 cycle, even if the FIFOs are already empty. Handover to the other port therefore takes at least 3 cycles after release.
- A `req` that drops and rises again in back-to-back cycles still passes through DRAIN and IDLE.
- Asynchronous reset mid-grant: outputs clear immediately. FIFO contents are the MCB's concern.

## Structure
- Shared package `mem_arb_pkg.vh`, included alongside `definitions.vh`, holds:
  - State encodings.
  - MCB field widths: 3, 6, 30, 4, 32.
  - The MCB write instruction constant.
- No sub-module: the FSM, mux and counter fit in one module of roughly 200 lines.

## Test plan
- Single requester: `req_0` held while pushing 16 `wr_en_0` words and one `cmd_en_0` (bl=15, addr 0x200) → MCB sees exactly 16 writes and 1 command; `gnt_0` rises 1 cycle after `req_0`.
- Tie after reset: `req_0` and `req_1` rise in the same cycle → `gnt_0` first. After release and drain, `gnt_1`. Next tie → `gnt_0`.
- Drain hold: `req_0` drops with `mem_wr_empty=0` for 10 cycles while `req_1` is high → `gnt_1` rises exactly 2 cycles after `mem_wr_empty` goes high.
- Isolation: port 1 toggles `wr_en_1` with data 0xDEADBEEF while port 0 owns the port → no 0xDEADBEEF on `mem_wr_data` with `mem_wr_en=1`; `wr_full_1=1` throughout.
- Timeout: `HOLD_MAX=100`, `req_1` held for 150 cycles → `timeout` sets at grant cycle 100 and stays set after release; `gnt_1` is never revoked.
- Reset: `reset_n` pulsed low while in GRANT1 mid-burst → all outputs 0 immediately, state IDLE, next tie goes to port 0.
